// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU datapath and the loader/debug port.
// Combinational same-cycle grants, anti-starvation for the loader, locked loader bursts.
module mem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          R,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic          ld_lock,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt_r;
    logic          lock_r;
    logic          rv_cpu_r;
    logic          rv_ld_r;
    logic          cpu_gnt_s;
    logic          ld_gnt_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;

    // Grant priority: locked burst, starved loader, CPU, then loader.
    always_comb begin
        cpu_gnt_s = 1'b0;
        ld_gnt_s  = 1'b0;
        if (ld_req && (lock_r || (wait_cnt_r == MAX_WAIT_C))) begin
            ld_gnt_s = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (ld_req) begin
            ld_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            ld_gnt_s  = 1'b0;
        end
    end

    // RAM request mux; idle cycles drive zeros so the bus is quiet.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        case ({cpu_gnt_s, ld_gnt_s})
            2'b10: begin
                mem_we_s    = cpu_we;
                mem_addr_s  = cpu_addr;
                mem_wdata_s = cpu_wdata;
            end
            2'b01: begin
                mem_we_s    = ld_we;
                mem_addr_s  = ld_addr;
                mem_wdata_s = ld_wdata;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_addr_s  = {AW{1'b0}};
                mem_wdata_s = {DW{1'b0}};
            end
        endcase
    end

    // Loader starvation counter, saturating at the forced-win threshold.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            wait_cnt_r <= 4'd0;
        end else if (ld_gnt_s) begin
            wait_cnt_r <= 4'd0;
        end else if (ld_req && (wait_cnt_r != MAX_WAIT_C)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Lock holds only while the loader keeps both req and lock asserted.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= ld_gnt_s & ld_lock;
        end
    end

    // Read-valid flags tag the returning RAM data with its owner.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            rv_cpu_r <= 1'b0;
            rv_ld_r  <= 1'b0;
        end else begin
            rv_cpu_r <= cpu_gnt_s & ~cpu_we;
            rv_ld_r  <= ld_gnt_s & ~ld_we;
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign ld_gnt     = ld_gnt_s;
    assign cpu_stall  = cpu_req & ~cpu_gnt_s;
    assign cpu_rvalid = rv_cpu_r;
    assign ld_rvalid  = rv_ld_r;
    assign cpu_rdata  = mem_rdata;
    assign ld_rdata   = mem_rdata;
    assign mem_en     = cpu_gnt_s | ld_gnt_s;
    assign mem_we     = mem_we_s;
    assign mem_addr   = mem_addr_s;
    assign mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of mem_arbiter against a cycle-level reference
// model of the grant rules, loader wait streak, lock and RAM contents.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          R = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .R(R),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 37 + 11);
    endfunction

    // Environment RAM: reloaded while reset is held, synchronous read.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (!R) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] mm [32];
    int            m_streak = 0;
    bit            m_lock = 1'b0;
    bit            p_cpu = 1'b0, p_ld = 1'b0;
    logic [DW-1:0] p_cpu_d = '0, p_ld_d = '0;
    int            obs_streak = 0;
    bit            e_cpu = 1'b0, e_ld = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mm[i] = init_val(i);
        m_streak = 0;
        m_lock = 1'b0;
        p_cpu = 1'b0;
        p_ld = 1'b0;
        obs_streak = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, advance the model.
    task automatic step(input logic creq, input logic cwe, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic lreq, input logic lwe,
                        input logic llock, input logic [AW-1:0] la, input logic [DW-1:0] ldat);
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        ld_req = lreq; ld_we = lwe; ld_lock = llock; ld_addr = la; ld_wdata = ldat;
        #1;
        e_ld  = lreq && (m_lock || (m_streak >= MAX_WAIT) || !creq);
        e_cpu = creq && !e_ld;
        x_we   = e_cpu ? cwe : (e_ld ? lwe : 1'b0);
        x_addr = e_cpu ? ca  : (e_ld ? la  : '0);
        x_wd   = e_cpu ? cd  : (e_ld ? ldat : '0);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
        chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
        chk("cpu_stall", 32'(cpu_stall), 32'(creq && !e_cpu));
        chk("mem_en", 32'(mem_en), 32'(e_cpu || e_ld));
        chk("mem_we", 32'(mem_we), 32'(x_we));
        chk("mem_addr", 32'(mem_addr), 32'(x_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(x_wd));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(p_cpu));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(p_ld));
        if (p_cpu) chk("cpu_rdata", 32'(cpu_rdata), 32'(p_cpu_d));
        if (p_ld)  chk("ld_rdata", 32'(ld_rdata), 32'(p_ld_d));
        chk("one_hot_gnt", 32'(cpu_gnt & ld_gnt), 32'd0);
        chk("mem_en_or", 32'(mem_en), 32'(cpu_gnt | ld_gnt));
        obs_streak = (ld_req && !ld_gnt) ? obs_streak + 1 : 0;
        chk("ld_denied_le_max", 32'(obs_streak <= MAX_WAIT), 32'd1);
        // advance model to the next edge
        p_cpu = e_cpu && !cwe;
        p_cpu_d = mm[ca];
        p_ld = e_ld && !lwe;
        p_ld_d = mm[la];
        if (e_cpu && cwe) mm[ca] = cd;
        if (e_ld && lwe)  mm[la] = ldat;
        if (e_ld)         m_streak = 0;
        else if (lreq)    m_streak = m_streak + 1;
        if (e_ld && llock)        m_lock = 1'b1;
        else if (!lreq || !llock) m_lock = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    // Assert reset mid-cycle; state must clear without waiting for a clock edge.
    task automatic do_reset();
        cpu_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
        R = 1'b0;
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("rst_gnt", 32'({cpu_gnt, ld_gnt, mem_en}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        model_reset();
        @(negedge clk);
        R = 1'b1;
    endtask

    bit            c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [AW-1:0] c_a = '0, l_a = '0;
    logic [DW-1:0] c_d = '0, l_d = '0;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // CPU-only reads of 0..4 back to back
        for (int a = 0; a < 5; a++) step(1'b1, 1'b0, 5'(a), 8'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        idle();

        // Both requesting: CPU for MAX_WAIT cycles, loader next, then CPU again
        for (int k = 0; k < MAX_WAIT + 2; k++)
            step(1'b1, 1'b0, 5'd3, 8'd0, 1'b1, 1'b0, 1'b0, 5'd9, 8'd0);
        idle();

        // Locked loader write burst to 0x1F while the CPU waits to read it
        step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 1'b1, 5'h1F, 8'hA5);
        step(1'b1, 1'b0, 5'h1F, 8'd0, 1'b1, 1'b1, 1'b1, 5'h1F, 8'hA5);
        step(1'b1, 1'b0, 5'h1F, 8'd0, 1'b1, 1'b1, 1'b1, 5'h1F, 8'hA5);
        step(1'b1, 1'b0, 5'h1F, 8'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        idle();
        chk("read_back_1f", 32'(mm[31]), 32'h0A5);

        // Loader read then CPU read: rvalids route to their own requester
        step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 5'd5, 8'd0);
        step(1'b1, 1'b0, 5'd6, 8'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        idle();
        idle();

        // Saturate the wait streak, reset right after a CPU read, then CPU must win
        for (int k = 0; k < MAX_WAIT; k++)
            step(1'b1, 1'b0, 5'd7, 8'd0, 1'b1, 1'b0, 1'b0, 5'd8, 8'd0);
        do_reset();
        step(1'b1, 1'b0, 5'd7, 8'd0, 1'b1, 1'b0, 1'b0, 5'd8, 8'd0);
        idle();

        // Reset while locked: lock must not survive
        step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b1, 5'd2, 8'd0);
        do_reset();
        step(1'b1, 1'b0, 5'd4, 8'd0, 1'b1, 1'b0, 1'b1, 5'd2, 8'd0);
        idle();

        // Randomised run; fields only change once the previous access was granted
        for (int n = 0; n < 1000; n++) begin
            if (!c_req || e_cpu) begin
                c_req = ($urandom_range(0, 99) < 60);
                c_we  = $urandom_range(0, 1) == 1;
                c_a   = 5'($urandom_range(0, 31));
                c_d   = 8'($urandom_range(0, 255));
            end
            if (!l_req || e_ld) begin
                l_req  = ($urandom_range(0, 99) < 50);
                l_we   = $urandom_range(0, 1) == 1;
                l_lock = ($urandom_range(0, 3) == 0);
                l_a    = 5'($urandom_range(0, 31));
                l_d    = 8'($urandom_range(0, 255));
            end
            step(c_req, c_we, c_a, c_d, l_req, l_we, l_lock, l_a, l_d);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
